// File: rtl/rv32i_decode_queue_pkg.sv
// Shared RV32I decode definitions: one-hot widths and bit indices, encoding constants, queue entry layout.
// The RV32M_DECODE_EN macro adds the mul_en bit to the decoded entry.
package rv32i_decode_queue_pkg;

  localparam int ALU_WIDTH       = 14;
  localparam int OPCODE_WIDTH    = 11;
  localparam int EXCEPTION_WIDTH = 4;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;
  localparam int ALU_EQ   = 10;
  localparam int ALU_NEQ  = 11;
  localparam int ALU_GE   = 12;
  localparam int ALU_GEU  = 13;

  localparam int OPC_RTYPE  = 0;
  localparam int OPC_ITYPE  = 1;
  localparam int OPC_LOAD   = 2;
  localparam int OPC_STORE  = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_JAL    = 5;
  localparam int OPC_JALR   = 6;
  localparam int OPC_LUI    = 7;
  localparam int OPC_AUIPC  = 8;
  localparam int OPC_SYSTEM = 9;
  localparam int OPC_FENCE  = 10;

  localparam int EXC_ILLEGAL = 0;
  localparam int EXC_ECALL   = 1;
  localparam int EXC_EBREAK  = 2;
  localparam int EXC_MRET    = 3;

  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [31:0]                imm;
    logic [2:0]                 funct3;
    logic [ALU_WIDTH-1:0]       alu;
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [EXCEPTION_WIDTH-1:0] exception;
`ifdef RV32M_DECODE_EN
    logic                       mul_en;
`endif
  } decoded_t;

  function automatic logic [ALU_WIDTH-1:0] alu_bit(input int idx);
    return {{(ALU_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Shared by R-type and I-type; only R-type may turn funct3 000 into SUB.
  function automatic logic [ALU_WIDTH-1:0] arith_alu(input logic [2:0] f3, input logic alt,
                                                     input logic allow_sub);
    case (f3)
      FUNCT3_ADD:  return (alt && allow_sub) ? alu_bit(ALU_SUB) : alu_bit(ALU_ADD);
      FUNCT3_SLL:  return alu_bit(ALU_SLL);
      FUNCT3_SLT:  return alu_bit(ALU_SLT);
      FUNCT3_SLTU: return alu_bit(ALU_SLTU);
      FUNCT3_XOR:  return alu_bit(ALU_XOR);
      FUNCT3_SR:   return alt ? alu_bit(ALU_SRA) : alu_bit(ALU_SRL);
      FUNCT3_OR:   return alu_bit(ALU_OR);
      default:     return alu_bit(ALU_AND);
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_queue_decode_comb.sv
// Purely combinational RV32I decoder: instruction word in, packed decoded queue entry out.
// RV32M_DECODE_EN makes funct7 0000001 a legal M-extension op.
module rv32i_decode_comb
  import rv32i_decode_queue_pkg::*;
(
  input  logic [31:0] i_inst,
  output decoded_t    o_entry
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_z;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];

  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};
  assign imm_z = {20'b0, i_inst[31:20]};

  always_comb begin
    o_entry        = '0;
    o_entry.rs1    = i_inst[19:15];
    o_entry.rs2    = i_inst[24:20];
    o_entry.rd     = i_inst[11:7];
    o_entry.funct3 = funct3;
    o_entry.alu    = alu_bit(ALU_ADD);
    case (opcode)
      OPCODE_RTYPE: begin
        o_entry.opcode[OPC_RTYPE] = 1'b1;
        o_entry.alu = arith_alu(funct3, i_inst[30], 1'b1);
        if (funct7 == FUNCT7_BASE) begin
        end else if (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_ADD || funct3 == FUNCT3_SR)) begin
`ifdef RV32M_DECODE_EN
        end else if (funct7 == FUNCT7_MULDIV) begin
          o_entry.mul_en = 1'b1;
          o_entry.alu    = '0;
`endif
        end else begin
          o_entry.exception[EXC_ILLEGAL] = 1'b1;
        end
      end
      OPCODE_ITYPE: begin
        o_entry.opcode[OPC_ITYPE] = 1'b1;
        o_entry.imm = imm_i;
        o_entry.alu = arith_alu(funct3, i_inst[30], 1'b0);
        // Shift amounts are 5 bits; inst[31:26] may only carry the SRAI select.
        if ((funct3 == FUNCT3_SLL || funct3 == FUNCT3_SR) &&
            (i_inst[25] || (i_inst[31:26] != 6'b000000 && i_inst[31:26] != 6'b010000)))
          o_entry.exception[EXC_ILLEGAL] = 1'b1;
      end
      OPCODE_LOAD:  begin o_entry.opcode[OPC_LOAD]  = 1'b1; o_entry.imm = imm_i; end
      OPCODE_STORE: begin o_entry.opcode[OPC_STORE] = 1'b1; o_entry.imm = imm_s; end
      OPCODE_BRANCH: begin
        o_entry.opcode[OPC_BRANCH] = 1'b1;
        o_entry.imm = imm_b;
        case (funct3)
          FUNCT3_BEQ:  o_entry.alu = alu_bit(ALU_EQ);
          FUNCT3_BNE:  o_entry.alu = alu_bit(ALU_NEQ);
          FUNCT3_BLT:  o_entry.alu = alu_bit(ALU_SLT);
          FUNCT3_BGE:  o_entry.alu = alu_bit(ALU_GE);
          FUNCT3_BLTU: o_entry.alu = alu_bit(ALU_SLTU);
          FUNCT3_BGEU: o_entry.alu = alu_bit(ALU_GEU);
          default:     o_entry.alu = alu_bit(ALU_ADD);
        endcase
      end
      OPCODE_JAL:   begin o_entry.opcode[OPC_JAL]   = 1'b1; o_entry.imm = imm_j; end
      OPCODE_JALR:  begin o_entry.opcode[OPC_JALR]  = 1'b1; o_entry.imm = imm_i; end
      OPCODE_LUI:   begin o_entry.opcode[OPC_LUI]   = 1'b1; o_entry.imm = imm_u; end
      OPCODE_AUIPC: begin o_entry.opcode[OPC_AUIPC] = 1'b1; o_entry.imm = imm_u; end
      OPCODE_SYSTEM: begin
        o_entry.opcode[OPC_SYSTEM] = 1'b1;
        o_entry.imm = imm_z;
        if (funct3 == 3'b000) begin
          case (i_inst[21:20])
            2'b00:   o_entry.exception[EXC_ECALL]  = 1'b1;
            2'b01:   o_entry.exception[EXC_EBREAK] = 1'b1;
            2'b10:   o_entry.exception[EXC_MRET]   = 1'b1;
            default: ;
          endcase
        end
      end
      OPCODE_FENCE: begin o_entry.opcode[OPC_FENCE] = 1'b1; o_entry.imm = imm_z; end
      default:      o_entry.exception[EXC_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_queue.sv
// RV32I decode stage feeding a DEPTH-entry valid/ready queue; head outputs come only from stored slots.
// RV32M_DECODE_EN enables M-extension decode and drives o_mul/o_mul_en.
module rv32i_decode_queue
  import rv32i_decode_queue_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_inst,
  input  logic [31:0]                i_pc,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_pc,
  output logic [4:0]                 o_rs1_addr,
  output logic [4:0]                 o_rs2_addr,
  output logic [4:0]                 o_rd_addr,
  output logic [31:0]                o_imm,
  output logic [2:0]                 o_funct3,
  output logic [ALU_WIDTH-1:0]       o_alu,
  output logic [OPCODE_WIDTH-1:0]    o_opcode,
  output logic [EXCEPTION_WIDTH-1:0] o_exception,
  output logic [2:0]                 o_mul,
  output logic                       o_mul_en,
  output logic [CNT_W-1:0]           o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  decoded_t          entry;
  decoded_t          head;
  decoded_t          slot_q [DEPTH];
  decoded_t          slot_d [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       pc_d   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  rv32i_decode_comb u_decode (
    .i_inst  (i_inst),
    .o_entry (entry)
  );

  // Ready looks only at the registered count, so a full queue never admits a push even while popping.
  assign o_ready = count_q < CNT_W'(DEPTH);
  assign o_valid = count_q != '0;
  assign o_count = count_q;
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready;

  always_comb begin
    slot_d   = slot_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      slot_d[wr_ptr_q] = entry;
      pc_d[wr_ptr_q]   = i_pc;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slot_q   <= slot_d;
      pc_q     <= pc_d;
    end
  end

  assign head        = slot_q[rd_ptr_q];
  assign o_pc        = pc_q[rd_ptr_q];
  assign o_rs1_addr  = head.rs1;
  assign o_rs2_addr  = head.rs2;
  assign o_rd_addr   = head.rd;
  assign o_imm       = head.imm;
  assign o_funct3    = head.funct3;
  assign o_alu       = head.alu;
  assign o_opcode    = head.opcode;
  assign o_exception = head.exception;

`ifdef RV32M_DECODE_EN
  assign o_mul_en = head.mul_en;
  assign o_mul    = head.mul_en ? head.funct3 : 3'b000;
`else
  assign o_mul_en = 1'b0;
  assign o_mul    = 3'b000;
`endif

endmodule
